// File: rtl/snd_irq_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : snd_irq_mailbox
//  Purpose  : Sound-board interrupt and command-mailbox controller. Captures
//             falling edges on NCHIP FM-chip irq_n lines into pending flags,
//             queues main-CPU command bytes in a FIFO of FIFO_DEPTH entries,
//             drives the sound Z80 INT_n and the main-CPU busy (ms) line,
//             and exposes a status port plus an active-low acknowledge port.
//  Ports    : clk           - system clock
//             rst           - synchronous reset, active-high
//             mcode_we_i    - main CPU command write strobe (1 clk)
//             mcode_din_i   - command byte
//             ms_o          - busy flag to main CPU
//             chip_irq_n_i  - FM chip irq_n lines, synchronous to clk
//             cmd_rd_i      - Z80 command-port read strobe (1 clk)
//             cmd_dout_o    - command byte read (valid 1 clk after cmd_rd_i)
//             stat_rd_i     - Z80 status-port read strobe (1 clk)
//             stat_dout_o   - status byte (valid 1 clk after stat_rd_i)
//             ack_we_i      - Z80 acknowledge-port write strobe (1 clk)
//             ack_din_i     - acknowledge byte, active-low bits
//             irq_n_o       - Z80 INT_n (registered)
//             ovf_o         - sticky command-FIFO overflow flag
//  Status   : [NCHIP-1:0] pend, [NCHIP] busy, [NCHIP+1] cmd pending,
//             [NCHIP+2] ovf, remaining upper bits read as 1.
//  Revision : 1.0 - initial release
// ============================================================================
module snd_irq_mailbox #(
    parameter int NCHIP      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit IRQ_ON_CMD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mcode_we_i,
    input  logic [7:0]       mcode_din_i,
    output logic             ms_o,
    input  logic [NCHIP-1:0] chip_irq_n_i,
    input  logic             cmd_rd_i,
    output logic [7:0]       cmd_dout_o,
    input  logic             stat_rd_i,
    output logic [7:0]       stat_dout_o,
    input  logic             ack_we_i,
    input  logic [7:0]       ack_din_i,
    output logic             irq_n_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    // Status / acknowledge bit positions above the per-chip flags
    localparam int C_B_BUSY = NCHIP;
    localparam int C_B_CMD  = NCHIP + 1;
    localparam int C_B_OVF  = NCHIP + 2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NCHIP-1:0] pend_q, pend_d;
    logic [NCHIP-1:0] irq_prev_q;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             irq_n_q, irq_n_d;
    logic [7:0]       cmd_dout_q, cmd_dout_d;
    logic [7:0]       stat_dout_q, stat_dout_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             w_cmd_pending;
    logic             w_full;
    logic             w_pop;
    logic             w_flush;
    logic             w_push;
    logic             w_drop;
    logic [NCHIP-1:0] w_edge;
    logic [NCHIP-1:0] w_ack_pend;
    logic             w_ack_busy;
    logic             w_ack_ovf;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_status;

    always_comb begin
        w_cmd_pending = (count_q != '0);
        w_full        = (count_q == C_DEPTH);
        w_pop         = cmd_rd_i && w_cmd_pending;
        w_flush       = ack_we_i && !ack_din_i[C_B_CMD];
        // A flush in the same clk empties the FIFO before the push lands,
        // so a push is never dropped alongside a flush.
        w_push        = mcode_we_i && (!w_full || w_pop || w_flush);
        w_drop        = mcode_we_i && !w_push;

        w_ack_pend    = ack_we_i ? ~ack_din_i[NCHIP-1:0] : '0;
        w_ack_busy    = ack_we_i && !ack_din_i[C_B_BUSY];
        w_ack_ovf     = ack_we_i && !ack_din_i[C_B_OVF];

        // Only a high-to-low transition raises a pending flag; a held-low
        // line stays quiet after it has been acknowledged.
        w_edge        = irq_prev_q & ~chip_irq_n_i;

        // Sets dominate same-cycle clears
        pend_d        = (pend_q & ~w_ack_pend) | w_edge;
        busy_d        = (busy_q & ~w_ack_busy) | mcode_we_i;
        ovf_d         = (ovf_q & ~w_ack_ovf) | w_drop;

        // Pointer and count update: the pop reads the pre-flush head, the
        // flush then resets the queue, and the push is applied last.
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        count_d       = count_q;
        if (w_flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else if (w_pop) begin
            rptr_d  = rptr_q + AW'(1);
        end

        w_waddr = wptr_d;
        if (w_push) begin
            wptr_d = w_waddr + AW'(1);
        end

        if (w_flush) begin
            count_d = w_push ? CW'(1) : '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        irq_n_d = ~((|pend_d) || (IRQ_ON_CMD && (count_d != '0)));

        // Status reflects the current (pre-update) state
        w_status           = 8'hFF;
        w_status[NCHIP-1:0] = pend_q;
        w_status[C_B_BUSY] = busy_q;
        w_status[C_B_CMD]  = w_cmd_pending;
        w_status[C_B_OVF]  = ovf_q;

        cmd_dout_d = cmd_dout_q;
        if (cmd_rd_i) begin
            cmd_dout_d = w_pop ? mem_q[rptr_q] : 8'hFF;
        end

        stat_dout_d = stat_dout_q;
        if (stat_rd_i) begin
            stat_dout_d = w_status;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            irq_prev_q  <= '1;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            irq_n_q     <= 1'b1;
            cmd_dout_q  <= 8'hFF;
            stat_dout_q <= 8'hFF;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            irq_prev_q  <= chip_irq_n_i;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            irq_n_q     <= irq_n_d;
            cmd_dout_q  <= cmd_dout_d;
            stat_dout_q <= stat_dout_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage: contents are don't-care while count is zero, so the
    // array carries no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[w_waddr] <= mcode_din_i;
        end
    end

    assign ms_o        = busy_q;
    assign ovf_o       = ovf_q;
    assign irq_n_o     = irq_n_q;
    assign cmd_dout_o  = cmd_dout_q;
    assign stat_dout_o = stat_dout_q;

endmodule
`default_nettype wire
